// File: rtl/arb_mux_1x8_pkg.sv
// Shared definitions for the two-requester arbiter.
//   arb_state_t : FSM encoding (IDLE, owner 0, owner 1)
//   ARB_BEAT_W  : width of the per-ownership beat counter
package arb_mux_1x8_pkg;

    localparam int ARB_BEAT_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mux_1x8.sv
// 2:1 selector on an 8-bit data path.
//   in1 : data chosen when key = 0
//   in2 : data chosen when key = 1
//   key : select
//   out : selected data (combinational)
module mux_1x8 (
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic       key,
    output logic [7:0] out
);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bit
            assign out[gi] = key ? in2[gi] : in1[gi];
        end
    endgenerate

endmodule

// File: rtl/arb_mux_1x8.sv
// Round-robin arbiter sharing one registered 8-bit output channel between
// two requesters. Ownership is bounded to MAX_BURST beats when the other
// requester is waiting.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req0/data0/ack0     : requester 0 beat, ack is combinational
//   req1/data1/ack1     : requester 1 beat, ack is combinational
//   out_valid/out_ready : output handshake
//   out_data/out_src    : registered beat and the requester that supplied it
//   busy                : FSM owned or output register occupied
module arb_mux_1x8
    import arb_mux_1x8_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_src,
    output logic       busy
);

    localparam logic [ARB_BEAT_W-1:0] MAX_BEATS = MAX_BURST[ARB_BEAT_W-1:0];

    arb_state_t            state_reg;
    logic                  last_reg;
    logic [ARB_BEAT_W-1:0] beats_reg;
    logic                  out_valid_reg;
    logic [7:0]            out_data_reg;
    logic                  out_src_reg;

    logic                  own0;
    logic                  own1;
    logic                  owner_req;
    logic                  other_req;
    logic                  slot_free;
    logic                  load;
    logic [ARB_BEAT_W-1:0] beats_next;
    logic                  burst_done;
    logic [7:0]            mux_out;

    assign own0       = (state_reg == ARB_OWN0);
    assign own1       = (state_reg == ARB_OWN1);
    assign owner_req  = own1 ? req1 : req0;
    assign other_req  = own1 ? req0 : req1;
    // The output register can take a new beat when empty or being drained
    // this same edge, which gives one beat per cycle under full throughput.
    assign slot_free  = !out_valid_reg || out_ready;
    assign ack0       = own0 && req0 && slot_free;
    assign ack1       = own1 && req1 && slot_free;
    assign load       = ack0 || ack1;
    assign beats_next = beats_reg + 1'b1;
    assign burst_done = (beats_next == MAX_BEATS);

    mux_1x8 u_mux (
        .in1 (data0),
        .in2 (data1),
        .key (own1),
        .out (mux_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ARB_IDLE;
            last_reg      <= 1'b1;
            beats_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= 8'h00;
            out_src_reg   <= 1'b0;
        end else begin
            if (load) begin
                out_data_reg  <= mux_out;
                out_src_reg   <= own1;
                out_valid_reg <= 1'b1;
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end

            case (state_reg)
                ARB_IDLE: begin
                    // On a tie the requester that did not own last wins.
                    if (req0 && (!req1 || last_reg)) begin
                        state_reg <= ARB_OWN0;
                        last_reg  <= 1'b0;
                        beats_reg <= '0;
                    end else if (req1) begin
                        state_reg <= ARB_OWN1;
                        last_reg  <= 1'b1;
                        beats_reg <= '0;
                    end
                end
                ARB_OWN0, ARB_OWN1: begin
                    if (!owner_req) begin
                        beats_reg <= '0;
                        if (other_req) begin
                            state_reg <= own0 ? ARB_OWN1 : ARB_OWN0;
                            last_reg  <= own0;
                        end else begin
                            state_reg <= ARB_IDLE;
                        end
                    end else if (load) begin
                        if (burst_done) begin
                            // Burst spent: hand over if the other side waits,
                            // otherwise start a fresh burst for this owner.
                            beats_reg <= '0;
                            if (other_req) begin
                                state_reg <= own0 ? ARB_OWN1 : ARB_OWN0;
                                last_reg  <= own0;
                            end
                        end else begin
                            beats_reg <= beats_next;
                        end
                    end
                end
                default: state_reg <= ARB_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_src   = out_src_reg;
    assign busy      = (state_reg != ARB_IDLE) || out_valid_reg;

endmodule
